// File: rtl/phase_arb_defs.sv
// Shared definitions for the phase-unit arbiter: tag width, FSM encoding, request operand pair.
package phase_arb_defs;
    localparam int MAX_NUM_REQ     = 4;
    localparam int PHASE_ARB_TAG_W = $clog2(MAX_NUM_REQ);

    typedef enum logic {
        S_RUN   = 1'b0,
        S_DRAIN = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic [31:0] i;
        logic [31:0] q;
    } phase_req_t;
endpackage

// File: rtl/tag_fifo.sv
// Synchronous FIFO of requester tags, kept in phase-unit issue order.
// Pushes while full and pops while empty are ignored.
module tag_fifo
    import phase_arb_defs::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic [PHASE_ARB_TAG_W-1:0] wdata,
    input  logic                       pop,
    output logic [PHASE_ARB_TAG_W-1:0] rdata,
    output logic                       full,
    output logic                       empty
);
    localparam int AW = $clog2(DEPTH);

    logic [PHASE_ARB_TAG_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]              r_wr;
    logic [AW-1:0]              r_rd;
    logic [AW:0]                r_cnt;
    logic                       w_push;
    logic                       w_pop;

    assign full   = (r_cnt == (AW+1)'(DEPTH));
    assign empty  = (r_cnt == '0);
    assign w_push = push & ~full;
    assign w_pop  = pop & ~empty;
    assign rdata  = r_mem[r_rd];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + AW'(1);
            if (w_pop)  r_rd <= r_rd + AW'(1);
            r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end

    always_ff @(posedge clock) begin
        if (w_push) r_mem[r_wr] <= wdata;
    end
endmodule

// File: rtl/phase_arbiter.sv
// Round-robin sharing of one phase (atan) unit among NUM_REQ requesters, with in-order result routing.
// Optional PHASE_ARB_STATS_EN adds saturating per-requester grant/drop counters.
module phase_arbiter
    import phase_arb_defs::*;
#(
    parameter int NUM_REQ   = 3,
    parameter int TAG_DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     enable,
    input  logic                     flush,
    input  logic [NUM_REQ-1:0][31:0] req_i,
    input  logic [NUM_REQ-1:0][31:0] req_q,
    input  logic [NUM_REQ-1:0]       req_stb,
    output logic [31:0]              phase_in_i,
    output logic [31:0]              phase_in_q,
    output logic                     phase_in_stb,
    input  logic [31:0]              phase_out,
    input  logic                     phase_out_stb,
    output logic [31:0]              rsp_phase,
    output logic [NUM_REQ-1:0]       rsp_stb,
    output logic [NUM_REQ-1:0]       overflow,
    output logic                     orphan,
    output logic                     state,
    output logic [NUM_REQ-1:0][15:0] grant_cnt,
    output logic [NUM_REQ-1:0][15:0] drop_cnt
);
    localparam int TAG_W = PHASE_ARB_TAG_W;

    arb_state_e                r_state;
    arb_state_e                w_next_state;
    logic [TAG_W-1:0]          r_rr;
    logic [NUM_REQ-1:0]        w_pend;
    phase_req_t [NUM_REQ-1:0]  w_op;
    logic [NUM_REQ-1:0]        w_cand;
    logic                      w_cap_en;
    logic                      w_rsp_en;
    logic                      w_gnt_vld;
    logic [TAG_W-1:0]          w_gnt_idx;
    logic [TAG_W:0]            w_sum;
    logic                      w_gnt;
    phase_req_t                w_iss;
    logic                      w_full;
    logic                      w_empty;
    logic [TAG_W-1:0]          w_tag;
    logic [NUM_REQ-1:0]        w_rsp_oh;

    // FSM: state register / next state / outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= S_RUN;
        else          r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_RUN:   if (flush)   w_next_state = w_empty ? S_RUN : S_DRAIN;
            S_DRAIN: if (w_empty) w_next_state = S_RUN;
            default: w_next_state = S_RUN;
        endcase
    end

    always_comb begin
        w_cap_en = (r_state == S_RUN) & ~flush;
        w_rsp_en = (r_state == S_RUN) & ~flush;
    end

    assign state = r_state;

    // A strobe is a grant candidate in its own cycle, so an idle requester issues one cycle later.
    assign w_cand = w_cap_en ? (w_pend | req_stb) : '0;

    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        w_sum     = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_sum = {1'b0, r_rr} + (TAG_W+1)'(k);
            if (w_sum >= (TAG_W+1)'(NUM_REQ)) w_sum = w_sum - (TAG_W+1)'(NUM_REQ);
            if (w_cand[w_sum[TAG_W-1:0]]) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = w_sum[TAG_W-1:0];
            end
        end
    end

    assign w_gnt    = w_gnt_vld & w_cap_en & enable & ~w_full;
    assign w_iss    = w_pend[w_gnt_idx] ? w_op[w_gnt_idx]
                                        : '{i: req_i[w_gnt_idx], q: req_q[w_gnt_idx]};
    assign w_rsp_oh = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_tag;

    for (genvar r = 0; r < NUM_REQ; r++) begin : g_req
        logic       r_pend;
        phase_req_t r_op;
        logic       r_ovf;
        logic       w_own_gnt;
        logic       w_ovw;

        assign w_own_gnt = w_gnt && (w_gnt_idx == TAG_W'(r));
        assign w_ovw     = w_cap_en & req_stb[r] & r_pend & ~w_own_gnt;

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                r_pend <= 1'b0;
                r_op   <= '0;
                r_ovf  <= 1'b0;
            end else if (!w_cap_en) begin
                r_pend <= 1'b0;
            end else begin
                if (req_stb[r]) r_op <= '{i: req_i[r], q: req_q[r]};
                r_pend <= w_own_gnt ? (r_pend & req_stb[r]) : (r_pend | req_stb[r]);
                if (w_ovw) r_ovf <= 1'b1;
            end
        end

        assign w_pend[r]   = r_pend;
        assign w_op[r]     = r_op;
        assign overflow[r] = r_ovf;

`ifdef PHASE_ARB_STATS_EN
        logic [15:0] r_gcnt;
        logic [15:0] r_dcnt;
        logic        w_drop;

        assign w_drop = w_ovw | (flush & r_pend & (r_state == S_RUN));

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                r_gcnt <= '0;
                r_dcnt <= '0;
            end else begin
                if (w_own_gnt && r_gcnt != 16'hFFFF) r_gcnt <= r_gcnt + 16'd1;
                if (w_drop && r_dcnt != 16'hFFFF)    r_dcnt <= r_dcnt + 16'd1;
            end
        end

        assign grant_cnt[r] = r_gcnt;
        assign drop_cnt[r]  = r_dcnt;
`else
        assign grant_cnt[r] = '0;
        assign drop_cnt[r]  = '0;
`endif
    end

    tag_fifo #(.DEPTH(TAG_DEPTH)) u_tag_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (w_gnt),
        .wdata   (w_gnt_idx),
        .pop     (phase_out_stb),
        .rdata   (w_tag),
        .full    (w_full),
        .empty   (w_empty)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rr         <= '0;
            phase_in_stb <= 1'b0;
            phase_in_i   <= '0;
            phase_in_q   <= '0;
            rsp_stb      <= '0;
            rsp_phase    <= '0;
            orphan       <= 1'b0;
        end else begin
            phase_in_stb <= w_gnt;
            if (w_gnt) begin
                phase_in_i <= w_iss.i;
                phase_in_q <= w_iss.q;
                r_rr       <= (w_gnt_idx == TAG_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + TAG_W'(1);
            end
            rsp_stb <= '0;
            // Returns during a flush or drain still pop their tag but are not delivered.
            if (phase_out_stb && !w_empty && w_rsp_en) begin
                rsp_stb   <= w_rsp_oh;
                rsp_phase <= phase_out;
            end
            if (phase_out_stb && w_empty) orphan <= 1'b1;
        end
    end
endmodule

// File: tb/tb_phase_arbiter.sv
// Scoreboard bench for phase_arbiter: directed stimulus pushes expected issues/responses,
// a negedge monitor pops and compares; a simple phase-unit model returns {I[15:0],Q[15:0]}.
module tb_phase_arbiter;
    logic             clock;
    logic             reset_n;
    logic             enable;
    logic             flush;
    logic [2:0][31:0] req_i;
    logic [2:0][31:0] req_q;
    logic [2:0]       req_stb;
    logic [31:0]      phase_in_i;
    logic [31:0]      phase_in_q;
    logic             phase_in_stb;
    logic [31:0]      phase_out;
    logic             phase_out_stb;
    logic [31:0]      rsp_phase;
    logic [2:0]       rsp_stb;
    logic [2:0]       overflow;
    logic             orphan;
    logic             state;
    logic [2:0][15:0] grant_cnt;
    logic [2:0][15:0] drop_cnt;

    phase_arbiter #(.NUM_REQ(3), .TAG_DEPTH(8)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .enable        (enable),
        .flush         (flush),
        .req_i         (req_i),
        .req_q         (req_q),
        .req_stb       (req_stb),
        .phase_in_i    (phase_in_i),
        .phase_in_q    (phase_in_q),
        .phase_in_stb  (phase_in_stb),
        .phase_out     (phase_out),
        .phase_out_stb (phase_out_stb),
        .rsp_phase     (rsp_phase),
        .rsp_stb       (rsp_stb),
        .overflow      (overflow),
        .orphan        (orphan),
        .state         (state),
        .grant_cnt     (grant_cnt),
        .drop_cnt      (drop_cnt)
    );

    typedef struct packed { logic [31:0] i; logic [31:0] q; } iss_t;
    typedef struct packed { logic [2:0] stb; logic [31:0] ph; } rsp_t;

    iss_t        exp_iss[$];
    rsp_t        exp_rsp[$];
    int          pm_due[$];
    logic [31:0] pm_val[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          pm_d = 4;
    int          pm_iss = 0;
    int          pm_ret = 0;
    int          pm_cnt_prev = 0;
    int          pm_peak = 0;
    int          bp_mode = 0;
    int          bp_iss = 0;
    int          bp_rsp = 0;
    int          last_iss_cyc = 0;
    int          last_rsp_cyc = 0;
    iss_t        mi;
    rsp_t        mr;

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(negedge clock);
            #1;
        end
    endtask

    task automatic chk_zero(input string p);
        chk({p, "_phase_in_stb"}, phase_in_stb, 0);
        chk({p, "_phase_in_i"}, phase_in_i, 0);
        chk({p, "_phase_in_q"}, phase_in_q, 0);
        chk({p, "_rsp_stb"}, rsp_stb, 0);
        chk({p, "_rsp_phase"}, rsp_phase, 0);
        chk({p, "_overflow"}, overflow, 0);
        chk({p, "_orphan"}, orphan, 0);
        chk({p, "_state"}, state, 0);
        chk({p, "_grant_cnt"}, grant_cnt, 0);
        chk({p, "_drop_cnt"}, drop_cnt, 0);
    endtask

    task automatic set_req(input int r, input logic [31:0] i, input logic [31:0] q);
        req_i[r] = i;
        req_q[r] = q;
    endtask

    task automatic wait_rsp(input string nm, input int budget);
        int n = 0;
        while (exp_rsp.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        chk({nm, "_drained"}, exp_rsp.size(), 0);
    endtask

    // Phase-unit model: result driven pm_d cycles after the issue is seen.
    always @(negedge clock) begin
        phase_out_stb = 1'b0;
        if (phase_in_stb) begin
            if (bp_mode != 0) chk("bp_grant_while_full", pm_cnt_prev >= 8, 0);
            pm_due.push_back(cyc + pm_d);
            pm_val.push_back({phase_in_i[15:0], phase_in_q[15:0]});
            pm_iss++;
        end
        pm_cnt_prev = pm_iss - pm_ret;
        if (bp_mode != 0 && pm_cnt_prev > pm_peak) pm_peak = pm_cnt_prev;
        if (pm_due.size() > 0 && pm_due[0] <= cyc) begin
            void'(pm_due.pop_front());
            phase_out     = pm_val.pop_front();
            phase_out_stb = 1'b1;
            pm_ret++;
        end
    end

    // Monitor: compare every issue and every response against the scoreboard.
    always @(negedge clock) begin
        if (reset_n) begin
            if (phase_in_stb) begin
                last_iss_cyc = cyc;
                if (bp_mode != 0) begin
                    chk("bp_issue_owner", phase_in_i < 3, 1);
                    exp_rsp.push_back('{stb: 3'b001 << phase_in_i[1:0],
                                        ph: {phase_in_i[15:0], phase_in_q[15:0]}});
                    bp_iss++;
                end else if (exp_iss.size() == 0) begin
                    chk("unexpected_issue", 1, 0);
                end else begin
                    mi = exp_iss.pop_front();
                    chk("issue_i", phase_in_i, mi.i);
                    chk("issue_q", phase_in_q, mi.q);
                end
            end
            if (rsp_stb != 3'b000) begin
                last_rsp_cyc = cyc;
                if (exp_rsp.size() == 0) begin
                    chk("unexpected_rsp", {61'd0, rsp_stb}, 0);
                end else begin
                    mr = exp_rsp.pop_front();
                    chk("rsp_owner", rsp_stb, mr.stb);
                    chk("rsp_phase", rsp_phase, mr.ph);
                    if (bp_mode != 0) bp_rsp++;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s_cyc;
        int base;
        int n;
        reset_n = 1'b0; enable = 1'b1; flush = 1'b0;
        req_i = '0; req_q = '0; req_stb = '0;
        phase_out = '0; phase_out_stb = 1'b0;
        tick(3);
        reset_n = 1'b1;
        tick();
        chk_zero("reset");

        // Single request on requester 2, latency 5.
        pm_d = 4;
        set_req(2, 32'd100, 32'hFFFF_FFCE);
        exp_iss.push_back('{i: 32'd100, q: 32'hFFFF_FFCE});
        exp_rsp.push_back('{stb: 3'b100, ph: 32'h0064_FFCE});
        req_stb = 3'b100; s_cyc = cyc;
        tick(); req_stb = '0;
        wait_rsp("single", 20);
        chk("single_issue_lat", last_iss_cyc - s_cyc, 1);
        chk("single_rsp_lat", last_rsp_cyc - last_iss_cyc, 5);

        // Requester 0 alone moves the round-robin pointer to 1.
        set_req(0, 32'd7, 32'd8);
        exp_iss.push_back('{i: 32'd7, q: 32'd8});
        exp_rsp.push_back('{stb: 3'b001, ph: 32'h0007_0008});
        req_stb = 3'b001;
        tick(); req_stb = '0;
        wait_rsp("single0", 20);

        // Contention twice: both rounds must issue 1, 2, 0 back to back.
        for (int rep = 0; rep < 2; rep++) begin
            for (int r = 0; r < 3; r++)
                set_req(r, 32'h1000 + 32'(rep * 16'h2000) + 32'(r), 32'h2000 + 32'(rep * 16'h2000) + 32'(r));
            exp_iss.push_back('{i: req_i[1], q: req_q[1]});
            exp_iss.push_back('{i: req_i[2], q: req_q[2]});
            exp_iss.push_back('{i: req_i[0], q: req_q[0]});
            exp_rsp.push_back('{stb: 3'b010, ph: {req_i[1][15:0], req_q[1][15:0]}});
            exp_rsp.push_back('{stb: 3'b100, ph: {req_i[2][15:0], req_q[2][15:0]}});
            exp_rsp.push_back('{stb: 3'b001, ph: {req_i[0][15:0], req_q[0][15:0]}});
            req_stb = 3'b111; s_cyc = cyc;
            tick(); req_stb = '0;
            wait_rsp("contention", 30);
            chk("contention_last_issue", last_iss_cyc - s_cyc, 3);
        end
        chk("overflow_clean", overflow, 3'b000);

        // Overflow: two strobes on requester 0 while disabled; the second operands issue.
        enable = 1'b0;
        set_req(0, 32'h0000_AAAA, 32'h0000_1111); req_stb = 3'b001;
        tick();
        set_req(0, 32'h0000_BBBB, 32'h0000_2222);
        tick(); req_stb = '0;
        tick();
        chk("overflow_set", overflow, 3'b001);
        exp_iss.push_back('{i: 32'h0000_BBBB, q: 32'h0000_2222});
        exp_rsp.push_back('{stb: 3'b001, ph: 32'hBBBB_2222});
        enable = 1'b1;
        wait_rsp("overflow", 20);
        chk("overflow_sticky", overflow, 3'b001);

        // Flush with 3 in flight and 2 pending.
        pm_d = 19;
        for (int r = 0; r < 3; r++) set_req(r, 32'h50 + 32'(r), 32'h58 + 32'(r));
        exp_iss.push_back('{i: 32'h51, q: 32'h59});
        exp_iss.push_back('{i: 32'h52, q: 32'h5A});
        exp_iss.push_back('{i: 32'h50, q: 32'h58});
        base = pm_ret;
        req_stb = 3'b111;
        tick(); req_stb = '0;
        tick(4);
        enable = 1'b0;
        set_req(0, 32'h60, 32'h61); set_req(1, 32'h62, 32'h63);
        req_stb = 3'b011;
        tick(); req_stb = '0;
        flush = 1'b1;
        tick(); flush = 1'b0;
        chk("flush_state_drain", state, 1);
        n = 0;
        while (pm_ret < base + 3 && n < 60) begin tick(); n++; end
        chk("flush_returns_seen", pm_ret - base, 3);
        chk("flush_state_before_last_pop", state, 1);
        tick(2);
        chk("flush_state_run", state, 0);
        enable = 1'b1;
        tick(6);
        chk("flush_orphan", orphan, 0);
        chk("flush_no_leftover_issue", exp_iss.size(), 0);

        // Backpressure: continuous strobes against a 20-cycle unit.
        bp_mode = 1;
        for (int s = 0; s < 40; s++) begin
            for (int r = 0; r < 3; r++) set_req(r, 32'(r), 32'(s));
            req_stb = 3'b111;
            tick();
        end
        req_stb = '0;
        n = 0;
        while ((exp_rsp.size() != 0 || pm_due.size() != 0 || cyc - last_iss_cyc < 3) && n < 300) begin
            tick(); n++;
        end
        chk("bp_drained", exp_rsp.size() + pm_due.size(), 0);
        chk("bp_peak_inflight", pm_peak, 8);
        chk("bp_rsp_count", bp_rsp, bp_iss);
        bp_mode = 0;

        // Async reset with 2 in flight; their returns become orphans.
        set_req(0, 32'h71, 32'h72); set_req(1, 32'h81, 32'h82);
        exp_iss.push_back('{i: 32'h71, q: 32'h72});
        exp_iss.push_back('{i: 32'h81, q: 32'h82});
        base = pm_ret;
        req_stb = 3'b001;
        tick(); req_stb = 3'b010;
        tick(); req_stb = '0;
        tick(3);
        chk("pre_reset_issued", exp_iss.size(), 0);
        #1 reset_n = 1'b0;
        #1 chk_zero("async_reset");
        exp_iss.delete();
        exp_rsp.delete();
        tick(); reset_n = 1'b1;
        n = 0;
        while (pm_ret < base + 2 && n < 60) begin tick(); n++; end
        chk("orphan_returns_seen", pm_ret - base, 2);
        tick(2);
        chk("orphan_set", orphan, 1);
        chk("orphan_state", state, 0);
        chk("end_exp_rsp_empty", exp_rsp.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
